bit_frame_sched: RTL and testbench

Bit-period scheduler and frame sequencer for the serial links. It owns the divider function for one link. It turns a runtime-programmable divisor into per-bit strobes and sequences a frame of N bit periods under a start/stop handshake. It sits between the link protocol logic, which requests frames and configures rates, and the shift registers, which consume `bit_stb` and `mid_stb`.

---
 rtl/bit_frame_sched_pkg.sv | 24 ++
 rtl/bit_frame_sched_tick_cnt.sv | 45 ++++
 rtl/bit_frame_sched.sv | 181 ++++++++++++++++++
 tb/tb_bit_frame_sched.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bit_frame_sched_pkg.sv
// ============================================================================
// Module   : bit_frame_sched_pkg
// Brief    : Shared state encoding, constants and helpers for bit_frame_sched.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bit_frame_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIV_MIN = 2;

    function automatic int default_div(input int freq_clk, input int freq_bit);
        return freq_clk / freq_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_frame_sched_tick_cnt.sv
// ============================================================================
// Module   : bit_tick_cnt
// Brief    : Reloadable bit-period down-counter with zero flag and optional
//            mid-bit compare (built when BIT_FRAME_SCHED_MID_STB_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bit_tick_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             sclr,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
`ifdef BIT_FRAME_SCHED_MID_STB_EN
    input  logic [DIV_W-1:0] mid_val,
    output logic             mid_hit,
`endif
    output logic             cnt_zero
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk_in) begin
        if (sclr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign cnt_zero = (r_cnt == '0);

`ifdef BIT_FRAME_SCHED_MID_STB_EN
    assign mid_hit = (r_cnt == mid_val);
`endif

endmodule

`default_nettype wire

// File: rtl/bit_frame_sched.sv
// ============================================================================
// Module   : bit_frame_sched
// Brief    : Bit-period scheduler and frame sequencer with runtime divisor.
//            Optional mid-bit strobe: define BIT_FRAME_SCHED_MID_STB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bit_frame_sched #(
    parameter int FREQ_CLK = 2_000_000,
    parameter int FREQ_BIT = 250_000,
    parameter int DIV_W    = 16,
    parameter int BITS_MAX = 16,
    parameter int BW       = $clog2(BITS_MAX + 1)
) (
    input  logic             clk_in,
    input  logic             sclr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [BW-1:0]    cfg_bits,
    input  logic             cfg_we,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             bit_stb,
    output logic             mid_stb,
    output logic [BW-1:0]    bit_idx,
    output logic             done,
    output logic             aborted,
    output logic             cfg_err
);

    import bit_frame_sched_pkg::*;

    localparam logic [DIV_W-1:0] c_DIV_RST  = DIV_W'(default_div(FREQ_CLK, FREQ_BIT));
    localparam logic [DIV_W-1:0] c_DIV_MIN  = DIV_W'(DIV_MIN);
    localparam logic [BW-1:0]    c_BITS_MAX = BW'(BITS_MAX);

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div_act, w_div_nxt, w_div_clamp, w_load_val;
    logic [BW-1:0]    r_bits_act, w_bits_nxt, w_bits_clamp;
    logic [BW-1:0]    r_bit_idx, w_bit_idx_nxt;
    logic             r_bit_stb, w_bit_stb_nxt;
    logic             r_done, w_done_nxt;
    logic             r_aborted, w_aborted_nxt;
    logic             r_cfg_err, w_cfg_err_nxt;
    logic             w_clamped, w_load, w_cnt_zero, w_last;

    always_comb begin
        w_div_clamp  = cfg_div;
        w_bits_clamp = cfg_bits;
        w_clamped    = 1'b0;
        if (cfg_div < c_DIV_MIN) begin
            w_div_clamp = c_DIV_MIN;
            w_clamped   = 1'b1;
        end
        if (cfg_bits == '0) begin
            w_bits_clamp = BW'(1);
            w_clamped    = 1'b1;
        end else if (cfg_bits > c_BITS_MAX) begin
            w_bits_clamp = c_BITS_MAX;
            w_clamped    = 1'b1;
        end
    end

    assign w_last = (r_bit_idx == (r_bits_act - BW'(1)));

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div_act;
        w_bits_nxt    = r_bits_act;
        w_bit_idx_nxt = r_bit_idx;
        w_bit_stb_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_cfg_err_nxt = 1'b0;
        w_load        = 1'b0;
        w_load_val    = r_div_act - DIV_W'(1);
        case (r_state)
            IDLE: begin
                if (cfg_we) begin
                    w_div_nxt     = w_div_clamp;
                    w_bits_nxt    = w_bits_clamp;
                    w_cfg_err_nxt = w_clamped;
                end
                // A same-cycle config write takes effect for this frame.
                if (start) begin
                    w_state_nxt   = RUN;
                    w_bit_idx_nxt = '0;
                    w_bit_stb_nxt = 1'b1;
                    w_load        = 1'b1;
                    w_load_val    = w_div_nxt - DIV_W'(1);
                end
            end
            RUN: begin
                w_cfg_err_nxt = cfg_we;
                if (stop) begin
                    w_state_nxt   = IDLE;
                    w_aborted_nxt = 1'b1;
                end else if (w_cnt_zero) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + BW'(1);
                        w_bit_stb_nxt = 1'b1;
                        w_load        = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (sclr) begin
            r_state    <= IDLE;
            r_div_act  <= c_DIV_RST;
            r_bits_act <= c_BITS_MAX;
            r_bit_idx  <= '0;
            r_bit_stb  <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div_act  <= w_div_nxt;
            r_bits_act <= w_bits_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_bit_stb  <= w_bit_stb_nxt;
            r_done     <= w_done_nxt;
            r_aborted  <= w_aborted_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
        end
    end

`ifdef BIT_FRAME_SCHED_MID_STB_EN
    logic             r_mid_stb, w_mid_hit;
    logic [DIV_W-1:0] w_mid_val;

    // Counter value one cycle before c == div>>1, since the strobe is registered.
    assign w_mid_val = r_div_act - (r_div_act >> 1);

    always_ff @(posedge clk_in) begin
        if (sclr) begin
            r_mid_stb <= 1'b0;
        end else begin
            r_mid_stb <= (r_state == RUN) && !stop && w_mid_hit;
        end
    end

    assign mid_stb = r_mid_stb;
`else
    assign mid_stb = 1'b0;
`endif

    bit_tick_cnt #(
        .DIV_W    (DIV_W)
    ) u_tick_cnt (
        .clk_in   (clk_in),
        .sclr     (sclr),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (r_state == RUN),
`ifdef BIT_FRAME_SCHED_MID_STB_EN
        .mid_val  (w_mid_val),
        .mid_hit  (w_mid_hit),
`endif
        .cnt_zero (w_cnt_zero)
    );

    assign busy    = (r_state == RUN);
    assign bit_stb = r_bit_stb;
    assign bit_idx = r_bit_idx;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign cfg_err = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_bit_frame_sched.sv
// ============================================================================
// Module   : tb_bit_frame_sched
// Brief    : Directed self-checking bench for bit_frame_sched.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bit_frame_sched;

`ifdef BIT_FRAME_SCHED_MID_STB_EN
    localparam bit c_MID_EN = 1'b1;
`else
    localparam bit c_MID_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        sclr, cfg_we, start, stop;
    logic [15:0] cfg_div;
    logic [4:0]  cfg_bits;
    logic        busy, bit_stb, mid_stb, done, aborted, cfg_err;
    logic [4:0]  bit_idx;
    logic [10:0] w_obs;

    int n_vec = 0;
    int n_bad = 0;

    bit_frame_sched u_dut (
        .clk_in   (clk_in),
        .sclr     (sclr),
        .cfg_div  (cfg_div),
        .cfg_bits (cfg_bits),
        .cfg_we   (cfg_we),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .bit_stb  (bit_stb),
        .mid_stb  (mid_stb),
        .bit_idx  (bit_idx),
        .done     (done),
        .aborted  (aborted),
        .cfg_err  (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    // {busy, bit_stb, mid_stb, done, aborted, cfg_err, bit_idx}
    assign w_obs = {busy, bit_stb, mid_stb, done, aborted, cfg_err, bit_idx};

    task automatic check_vec(input string tag, input logic [10:0] got, input logic [10:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Starts a frame in the current cycle (cycle 0) and checks every cycle up to
    // the done/aborted/reset response. kill_kind: 0 none, 1 stop, 2 sclr at kill_at.
    task automatic run_frame(input string name, input int div, input int bits,
                             input bit we, input int wdiv, input int wbits, input bit err0,
                             input int kill_at, input int kill_kind, input int we_at);
        int          len, endc, k, c;
        bit          act;
        logic [10:0] e;
        len      = div * bits;
        endc     = (kill_kind != 0) ? kill_at + 1 : len + 1;
        start    = 1'b1;
        cfg_we   = we;
        cfg_div  = 16'(wdiv);
        cfg_bits = 5'(wbits);
        for (int n = 1; n <= endc; n++) begin
            step();
            start  = 1'b0;
            cfg_we = 1'b0;
            stop   = 1'b0;
            sclr   = 1'b0;
            act    = (n <= len) && (kill_kind == 0 || n <= kill_at);
            k      = (n - 1) / div;
            c      = (n - 1) % div;
            e      = '0;
            if (!(kill_kind == 2 && n == endc)) begin
                e[10]  = act;
                e[9]   = act && (c == 0);
                e[8]   = c_MID_EN && act && (c == div / 2);
                e[7]   = (kill_kind == 0) && (n == len + 1);
                e[6]   = (kill_kind == 1) && (n == endc);
                e[5]   = (err0 && n == 1) || (we_at > 0 && n == we_at + 1);
                e[4:0] = act ? 5'(k) : 5'((endc - 2) / div);
            end
            check_vec($sformatf("%s cyc%0d", name, n), w_obs, e);
            if (n == kill_at && kill_kind == 1) stop = 1'b1;
            if (n == kill_at && kill_kind == 2) sclr = 1'b1;
            if (n == we_at) begin
                cfg_we   = 1'b1;
                start    = 1'b1;
                cfg_div  = 16'(wdiv);
                cfg_bits = 5'(wbits);
            end
        end
    endtask

    initial begin
        sclr     = 1'b1;
        cfg_we   = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        cfg_div  = '0;
        cfg_bits = '0;
        repeat (2) step();
        check_vec("reset", w_obs, 11'd0);
        sclr = 1'b0;

        run_frame("default",    8, 16, 1'b0, 0, 0,  1'b0, 0, 0, 0);
        run_frame("cfg3x4",     3, 4,  1'b1, 3, 4,  1'b0, 0, 0, 0);
        run_frame("clamp_div",  2, 4,  1'b1, 0, 4,  1'b1, 0, 0, 0);
        run_frame("clamp_bits", 3, 16, 1'b1, 3, 20, 1'b1, 0, 0, 0);
        run_frame("we_in_run",  3, 16, 1'b0, 5, 2,  1'b0, 0, 0, 10);
        run_frame("abort",      8, 16, 1'b1, 8, 16, 1'b0, 40, 1, 0);
        run_frame("restart",    8, 16, 1'b0, 0, 0,  1'b0, 0, 0, 0);

        stop = 1'b1;
        step();
        stop = 1'b0;
        check_vec("stop_idle", w_obs, 11'd15);

        run_frame("coinc_abort", 4, 1, 1'b1, 4, 1, 1'b0, 4, 1, 0);
        run_frame("coinc_done",  4, 1, 1'b0, 0, 0, 1'b0, 0, 0, 0);
        run_frame("sclr_mid",    6, 16, 1'b1, 6, 16, 1'b0, 50, 2, 0);
        run_frame("post_sclr",   8, 16, 1'b0, 0, 0,  1'b0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
